// File: rtl/mux_pkg.sv
// Shared types and default sizing for the mux_scanner block.
package mux_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 8;
    localparam int DEF_DWELL    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DIRECT = 2'b01,
        SCAN   = 2'b10
    } mux_state_e;

    // A DWELL of 1 would give a zero-width counter, so keep at least one bit.
    function automatic int cnt_width(input int dwell);
        return (dwell > 1) ? $clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/mux_dwell_ctr.sv
// Channel register and per-channel dwell counter for the scanner.
module mux_dwell_ctr
    import mux_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DWELL    = DEF_DWELL,
    localparam int SEL_W   = $clog2(CHANNELS),
    localparam int CNT_W   = cnt_width(DWELL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scan_step,
    input  logic             state_chg,
    input  logic             sel_load,
    input  logic [SEL_W-1:0] sel,
    output logic [SEL_W-1:0] ch,
    output logic [CNT_W-1:0] cnt
);

    logic [SEL_W-1:0] ch_r;
    logic [CNT_W-1:0] cnt_r;
    logic             cnt_last_s;
    logic             advance_s;
    logic [SEL_W-1:0] ch_next_s;

    // Decide whether this capture completes the dwell and where the scan goes next.
    always_comb begin
        cnt_last_s = 1'b0;
        advance_s  = 1'b0;
        ch_next_s  = ch_r;
        cnt_last_s = (cnt_r == CNT_W'(DWELL - 1));
        // A state change restarts the dwell rather than advancing the channel.
        advance_s  = scan_step && !state_chg && cnt_last_s;
        if (ch_r == SEL_W'(CHANNELS - 1)) begin
            ch_next_s = '0;
        end else begin
            ch_next_s = ch_r + SEL_W'(1);
        end
    end

    // Channel and dwell registers; an explicit select always wins over the scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_r  <= '0;
            cnt_r <= '0;
        end else begin
            if (sel_load) begin
                ch_r <= sel;
            end else if (advance_s) begin
                ch_r <= ch_next_s;
            end else begin
                ch_r <= ch_r;
            end

            if (state_chg || sel_load) begin
                cnt_r <= '0;
            end else if (scan_step) begin
                cnt_r <= cnt_last_s ? '0 : (cnt_r + CNT_W'(1));
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign ch  = ch_r;
    assign cnt = cnt_r;

endmodule

// File: rtl/mux_scanner.sv
// Channel multiplexer with direct-select and auto-scan modes and a
// valid/ready registered output. Define MUX_SCANNER_RANGE_CHK_EN to flag
// out-of-range selects on sel_err.
module mux_scanner
    import mux_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int DWELL    = DEF_DWELL,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      mode,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      sel_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      sel_err
);

    localparam int CNT_W = cnt_width(DWELL);
    localparam logic [SEL_W:0] CH_LIMIT = (SEL_W + 1)'(CHANNELS);

    mux_state_e       state_r;
    mux_state_e       state_nxt_s;
    logic [WIDTH-1:0] out_data_r;
    logic [SEL_W-1:0] out_ch_r;
    logic             out_valid_r;

    logic             slot_free_s;
    logic             capture_s;
    logic             state_chg_s;
    logic             sel_in_range_s;
    logic             sel_load_s;
    logic             scan_step_s;
    logic [WIDTH-1:0] chan_sample_s;
    logic [SEL_W-1:0] ch_s;
    logic [CNT_W-1:0] cnt_s;
    logic             zero_pend_s;

    // Next-state decode: en and mode alone pick the operating state.
    always_comb begin
        state_nxt_s = IDLE;
        case ({en, mode})
            2'b10:   state_nxt_s = DIRECT;
            2'b11:   state_nxt_s = SCAN;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture qualification and select decode.
    always_comb begin
        slot_free_s    = 1'b0;
        capture_s      = 1'b0;
        state_chg_s    = 1'b0;
        sel_in_range_s = 1'b0;
        sel_load_s     = 1'b0;
        scan_step_s    = 1'b0;
        chan_sample_s  = '0;
        slot_free_s    = !out_valid_r || out_ready;
        capture_s      = (state_r != IDLE) && slot_free_s;
        state_chg_s    = (state_nxt_s != state_r);
        sel_in_range_s = ({1'b0, sel} < CH_LIMIT);
        sel_load_s     = sel_valid && sel_in_range_s;
        scan_step_s    = capture_s && (state_r == SCAN);
        chan_sample_s  = in_data[int'(ch_s) * WIDTH +: WIDTH];
    end

    mux_dwell_ctr #(
        .CHANNELS (CHANNELS),
        .DWELL    (DWELL)
    ) u_dwell_ctr (
        .clk       (clk),
        .rst       (rst),
        .scan_step (scan_step_s),
        .state_chg (state_chg_s),
        .sel_load  (sel_load_s),
        .sel       (sel),
        .ch        (ch_s),
        .cnt       (cnt_s)
    );

`ifdef MUX_SCANNER_RANGE_CHK_EN
    logic sel_err_r;
    logic zero_pend_r;
    logic sel_bad_s;

    assign sel_bad_s = sel_valid && !sel_in_range_s;

    // Sticky error flag plus a one-shot request to blank the next captured sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_r   <= 1'b0;
            zero_pend_r <= 1'b0;
        end else if (sel_bad_s) begin
            sel_err_r   <= 1'b1;
            zero_pend_r <= 1'b1;
        end else if (capture_s) begin
            sel_err_r   <= sel_err_r;
            zero_pend_r <= 1'b0;
        end else begin
            sel_err_r   <= sel_err_r;
            zero_pend_r <= zero_pend_r;
        end
    end

    assign sel_err     = sel_err_r;
    assign zero_pend_s = zero_pend_r;
`else
    assign sel_err     = 1'b0;
    assign zero_pend_s = 1'b0;
`endif

    // Output register: capture when the slot is free, otherwise hold for the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_r  <= '0;
            out_ch_r    <= '0;
            out_valid_r <= 1'b0;
        end else if (capture_s) begin
            out_data_r  <= zero_pend_s ? '0 : chan_sample_s;
            out_ch_r    <= ch_s;
            out_valid_r <= 1'b1;
        end else if (slot_free_s) begin
            out_data_r  <= out_data_r;
            out_ch_r    <= out_ch_r;
            out_valid_r <= 1'b0;
        end else begin
            out_data_r  <= out_data_r;
            out_ch_r    <= out_ch_r;
            out_valid_r <= out_valid_r;
        end
    end

    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_scanner.sv
// Self-checking bench for mux_scanner: two instances (8 ch / dwell 2 and
// 6 ch / dwell 3) driven together and compared against a behavioural model.
module tb_mux_scanner;

`ifdef MUX_SCANNER_RANGE_CHK_EN
    localparam bit RCHK = 1'b1;
`else
    localparam bit RCHK = 1'b0;
`endif

    typedef struct {
        int state;   // 0 idle, 1 direct, 2 scan
        int ch;
        int cnt;
        int odata;
        int och;
        bit ovalid;
        bit err;
        bit pend;
    } model_t;

    logic        clk = 1'b0;
    logic        rst, en, mode, sel_valid, out_ready;
    logic [2:0]  sel;
    logic [63:0] in_data64;
    logic [47:0] in_data6;
    logic [7:0]  out_data8, out_data6;
    logic [2:0]  out_ch8, out_ch6;
    logic        out_valid8, out_valid6, sel_err8, sel_err6;

    int tests = 0;
    int fails = 0;
    model_t m8, m6;

    assign in_data6 = in_data64[47:0];

    always #5 clk = ~clk;

    mux_scanner #(.WIDTH(8), .CHANNELS(8), .DWELL(2)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_data(in_data64),
        .sel(sel), .sel_valid(sel_valid), .out_data(out_data8), .out_ch(out_ch8),
        .out_valid(out_valid8), .out_ready(out_ready), .sel_err(sel_err8)
    );

    mux_scanner #(.WIDTH(8), .CHANNELS(6), .DWELL(3)) dut6 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_data(in_data6),
        .sel(sel), .sel_valid(sel_valid), .out_data(out_data6), .out_ch(out_ch6),
        .out_valid(out_valid6), .out_ready(out_ready), .sel_err(sel_err6)
    );

    function automatic model_t mreset();
        model_t r;
        r.state = 0; r.ch = 0; r.cnt = 0; r.odata = 0; r.och = 0;
        r.ovalid = 1'b0; r.err = 1'b0; r.pend = 1'b0;
        return r;
    endfunction

    // One clock of the reference behaviour, from the rules as written.
    function automatic model_t mstep(model_t m, int nch, int dwell, logic [63:0] din);
        model_t n = m;
        int  nxt;
        bit  chg, free, cap, load, bad, scan_cap;
        if (rst) return mreset();
        nxt  = !en ? 0 : (mode ? 2 : 1);
        chg  = (nxt != m.state);
        free = !m.ovalid || out_ready;
        cap  = (m.state != 0) && free;
        load = sel_valid && (int'(sel) < nch);
        bad  = RCHK && sel_valid && (int'(sel) >= nch);
        scan_cap = cap && (m.state == 2);
        if (cap) begin
            n.odata  = m.pend ? 0 : int'(din[m.ch*8 +: 8]);
            n.och    = m.ch;
            n.ovalid = 1'b1;
            n.pend   = 1'b0;
        end else if (free) begin
            n.ovalid = 1'b0;
        end
        if (bad) begin
            n.err  = 1'b1;
            n.pend = 1'b1;
        end
        if (load) n.ch = int'(sel);
        else if (scan_cap && !chg && (m.cnt + 1 == dwell)) n.ch = (m.ch + 1) % nch;
        if (chg || load) n.cnt = 0;
        else if (scan_cap) n.cnt = (m.cnt + 1) % dwell;
        n.state = nxt;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all();
        chk("d8_data",  {24'd0, out_data8},  m8.odata);
        chk("d8_ch",    {29'd0, out_ch8},    m8.och);
        chk("d8_valid", {31'd0, out_valid8}, {31'd0, m8.ovalid});
        chk("d8_err",   {31'd0, sel_err8},   {31'd0, m8.err});
        chk("d6_data",  {24'd0, out_data6},  m6.odata);
        chk("d6_ch",    {29'd0, out_ch6},    m6.och);
        chk("d6_valid", {31'd0, out_valid6}, {31'd0, m6.ovalid});
        chk("d6_err",   {31'd0, sel_err6},   {31'd0, m6.err});
    endtask

    task automatic step_cycle();
        m8 = mstep(m8, 8, 2, in_data64);
        m6 = mstep(m6, 6, 3, {16'd0, in_data64[47:0]});
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic load_pattern();
        for (int k = 0; k < 8; k++) in_data64[k*8 +: 8] = 8'(8'h10 + k);
    endtask

    initial begin
        int  hold_d, hold_c, prev_ch6;
        bit  found;
        rst = 1'b1; en = 1'b0; mode = 1'b0; sel_valid = 1'b0; out_ready = 1'b1;
        sel = 3'd0; in_data64 = 64'd0;
        m8 = mreset(); m6 = mreset();

        // Reset state
        step_cycle();
        step_cycle();
        chk("rst_valid", {31'd0, out_valid8}, 32'd0);

        // Direct select of channel 5
        rst = 1'b0; en = 1'b1; mode = 1'b0; load_pattern();
        step_cycle();
        step_cycle();
        sel = 3'd5; sel_valid = 1'b1;
        step_cycle();
        sel_valid = 1'b0;
        step_cycle();
        chk("direct_data", {24'd0, out_data8}, 32'h15);
        chk("direct_ch",   {29'd0, out_ch8},   32'd5);

        // Out-of-range select on the 6-channel instance
        prev_ch6 = m6.ch;
        sel = 3'd7; sel_valid = 1'b1;
        step_cycle();
        sel_valid = 1'b0;
        chk("oor_err", {31'd0, sel_err6}, {31'd0, RCHK});
        step_cycle();
        chk("oor_data", {24'd0, out_data6}, RCHK ? 32'd0 : 32'(8'h10 + prev_ch6));
        chk("oor_ch",   {29'd0, out_ch6},   32'(prev_ch6));

        // Scan wrap from channel 0
        rst = 1'b1;
        step_cycle();
        rst = 1'b0; en = 1'b1; mode = 1'b1;
        step_cycle();
        step_cycle();
        for (int i = 0; i < 18; i++) begin
            chk("wrap_ch", {29'd0, out_ch8}, 32'((i / 2) % 8));
            step_cycle();
        end

        // Backpressure mid-scan with changing inputs
        hold_d = m8.odata; hold_c = m8.och;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data64 = {$urandom, $urandom};
            step_cycle();
            chk("bp_data", {24'd0, out_data8}, 32'(hold_d));
            chk("bp_ch",   {29'd0, out_ch8},   32'(hold_c));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data64 = {$urandom, $urandom};
            step_cycle();
        end

        // Select colliding with a due scan advance
        load_pattern();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (m8.state == 2 && m8.cnt == 1) found = 1'b1;
            else step_cycle();
        end
        chk("coll_found", {31'd0, found}, 32'd1);
        sel = 3'd3; sel_valid = 1'b1;
        step_cycle();
        sel_valid = 1'b0;
        step_cycle();
        chk("coll_ch_a", {29'd0, out_ch8}, 32'd3);
        step_cycle();
        chk("coll_ch_b", {29'd0, out_ch8},   32'd3);
        chk("coll_data", {24'd0, out_data8}, 32'h13);
        step_cycle();
        chk("coll_next", {29'd0, out_ch8}, 32'd4);

        // Reset during a stalled scan
        out_ready = 1'b0;
        step_cycle();
        step_cycle();
        rst = 1'b1;
        step_cycle();
        chk("mid_rst_data",  {24'd0, out_data8},  32'd0);
        chk("mid_rst_ch",    {29'd0, out_ch8},    32'd0);
        chk("mid_rst_valid", {31'd0, out_valid8}, 32'd0);
        chk("mid_rst_err",   {31'd0, sel_err6},   32'd0);
        rst = 1'b0; out_ready = 1'b1;
        step_cycle();
        chk("post_rst_valid", {31'd0, out_valid8}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 99) < 2);
            en        = ($urandom_range(0, 99) < 90);
            if ($urandom_range(0, 99) < 10) mode = ~mode;
            out_ready = ($urandom_range(0, 99) < 70);
            sel_valid = ($urandom_range(0, 99) < 10);
            sel       = 3'($urandom_range(0, 7));
            in_data64 = {$urandom, $urandom};
            step_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_scanner.md
MUX_SCANNER -- requirements
Module: mux_scanner

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of each input channel.
REQ-002 SHALL have parameter CHANNELS, default 8, number of input channels, legal range 2..64.
REQ-003 SHALL have parameter DWELL, default 4, clock cycles spent on each channel in scan mode, minimum 1.
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge triggered.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  1  block enable; low stops new captures.
REQ-007 SHALL have port mode  input  1  0 = direct select, 1 = auto-scan.
REQ-008 SHALL have port in_data  input  CHANNELS*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port sel  input  $clog2(CHANNELS)  requested channel index.
REQ-010 SHALL have port sel_valid  input  1  loads sel into the channel register.
REQ-011 SHALL have port out_data  output  WIDTH  registered selected sample.
REQ-012 SHALL have port out_ch  output  $clog2(CHANNELS)  channel index of out_data.
REQ-013 SHALL have port out_valid  output  1  out_data/out_ch hold a sample.
REQ-014 SHALL have port out_ready  input  1  consumer accepts the sample when out_valid && out_ready.
REQ-015 SHALL have port sel_err  output  1  sticky out-of-range select flag (see Configuration).

Function
REQ-016 SHALL implement states IDLE, DIRECT, SCAN: en=0 -> IDLE; en=1 && mode=0 -> DIRECT; en=1 && mode=1 -> SCAN; state updates on the next clock edge.
REQ-017 SHALL define the output slot as free when !out_valid || out_ready.
REQ-018 SHALL, in DIRECT or SCAN with a free slot, capture in_data of the current channel into out_data, with out_ch and out_valid=1, at the next edge (1-cycle latency).
REQ-019 SHALL hold out_data, out_ch, out_valid stable while out_valid && !out_ready.
REQ-020 SHALL, in IDLE, make no new captures; out_valid clears once the pending sample is accepted.
REQ-021 SHALL, on sel_valid with in-range sel, load the channel register at the next edge in any state; the sample captured in that same cycle still uses the old channel.
REQ-022 SHALL, in SCAN, increment the dwell counter on each capture; after DWELL captures, advance the channel by 1, wrapping CHANNELS-1 -> 0, and clear the counter.
REQ-023 SHALL stall the dwell counter and channel advance while the slot is not free (backpressure).
REQ-024 SHALL, when sel_valid and a scan advance coincide, give sel_valid priority and clear the dwell counter.
REQ-025 SHALL clear the dwell counter on any state change; scanning resumes from the current channel.

Reset
REQ-026 SHALL, with rst high, set state IDLE, channel 0, dwell counter 0, out_data 0, out_ch 0, out_valid 0, sel_err 0 at the next edge.
REQ-027 SHALL give rst priority over all other inputs, including mid-scan and mid-stall; pending samples are discarded.

Configuration
REQ-028 SHALL, with MUX_SCANNER_RANGE_CHK_EN defined, treat sel_valid with sel >= CHANNELS as an error: set sel_err (sticky until rst), load no channel, and make the next captured out_data 0.
REQ-029 SHALL, without MUX_SCANNER_RANGE_CHK_EN, tie sel_err to 0 and ignore out-of-range sel_valid with no other effect.

Structure
REQ-030 SHALL place the state enumeration typedef and the default WIDTH/CHANNELS/DWELL constants in shared package mux_pkg.
REQ-031 SHALL use one sub-module, mux_dwell_ctr, holding the dwell counter and channel-advance logic; the output register and FSM stay in the top.

Verification
REQ-032 SHALL cover direct select: CHANNELS=8, in ch k = 8'h10+k, sel=5 pulse, out_ready=1 -> out_data=8'h15, out_ch=5 one cycle after the channel loads.
REQ-033 SHALL cover scan wrap: DWELL=2, mode=1, out_ready=1 -> out_ch sequence 0,0,1,1,...,7,7,0,0.
REQ-034 SHALL cover backpressure: out_ready=0 for 5 cycles mid-scan -> out_data/out_ch frozen, dwell count unchanged, resume with no sample lost or skipped.
REQ-035 SHALL cover collision: sel_valid sel=3 on the cycle a scan advance is due -> channel becomes 3, dwell restarts, next DWELL samples from ch 3.
REQ-036 SHALL cover out-of-range select: CHANNELS=6, sel=7 -> with macro, sel_err=1 and next out_data=0; without macro, sel_err=0 and channel unchanged.
REQ-037 SHALL cover reset mid-operation: rst during SCAN with out_valid=1 -> next cycle all outputs 0, state IDLE.
